// File: rtl/dyuv_line_sequencer.sv
// rtl/dyuv_line_sequencer.sv - per-scanline reset/start-YUV/byte-forwarding/pixel-count controller for one DYUV decoder
// Optional stall statistics output enabled by DYUV_LINE_STATS_EN.
module dyuv_line_sequencer #(
  parameter int PIPE_DEPTH    = 2,
  parameter int RESET_CYCLES  = 2,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_start,
  input  logic        dyuv_en,
  input  logic        st,
  input  logic [23:0] start_yuv,
  input  logic        start_yuv_we,
  input  logic        fifo_write,
  input  logic [7:0]  fifo_pixel,
  output logic        fifo_strobe,
  output logic        dec_reset,
  output logic        dec_st,
  output logic [23:0] dec_start_yuv,
  output logic        dec_src_write,
  output logic [7:0]  dec_src_pixel,
  input  logic        dec_src_strobe,
  input  logic        dec_write,
  input  logic        dec_strobe,
  output logic        busy,
  output logic        line_done,
  output logic        line_abort,
`ifdef DYUV_LINE_STATS_EN
  output logic [15:0] stall_cnt,
`endif
  output logic        timeout
);

  localparam int DW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [DW-1:0] DRAIN_MAX = DW'(DRAIN_TIMEOUT);
  localparam logic [2:0]    RST_LAST  = 3'(RESET_CYCLES - 1);
  localparam logic [8:0]    PIPE      = 9'(PIPE_DEPTH);
  localparam logic [8:0]    CNT_MAX   = 9'd511;

  typedef enum logic [1:0] {IDLE, RST, RUN, DRAIN} state_t;

  state_t        state, state_nx;
  logic [8:0]    width, byte_cnt, pix_cnt;
  logic [2:0]    rst_cnt;
  logic [DW-1:0] drain_cnt;
  logic [23:0]   shadow;
  logic          accept_line, byte_acc, pix_acc, last_byte, drain_done, drain_expired;

  assign accept_line   = line_start && dyuv_en;
  assign busy          = (state != IDLE);
  assign line_abort    = line_start && busy;
  assign dec_src_write = (state == RUN) && fifo_write && (byte_cnt < width);
  assign dec_src_pixel = fifo_pixel;
  // The FIFO is only popped when a valid byte was actually handed over.
  assign byte_acc      = dec_src_write && dec_src_strobe;
  assign fifo_strobe   = byte_acc;
  assign pix_acc       = ((state == RUN) || (state == DRAIN)) && dec_write && dec_strobe;
  assign last_byte     = byte_acc && (byte_cnt == width - 9'd1);
  assign drain_done    = (state == DRAIN) && (pix_cnt == width - PIPE);
  assign drain_expired = (state == DRAIN) && (drain_cnt == DRAIN_MAX);

  always_comb begin
    state_nx  = state;
    line_done = 1'b0;
    timeout   = 1'b0;
    if (line_start) begin
      state_nx = dyuv_en ? RST : IDLE;
    end else begin
      case (state)
        RST:     if (rst_cnt == RST_LAST) state_nx = RUN;
        RUN:     if (last_byte) state_nx = DRAIN;
        DRAIN: begin
          if (drain_done) begin
            line_done = 1'b1;
            state_nx  = IDLE;
          end else if (drain_expired) begin
            line_done = 1'b1;
            timeout   = 1'b1;
            state_nx  = IDLE;
          end
        end
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      dec_reset     <= 1'b0;
      dec_st        <= 1'b0;
      dec_start_yuv <= 24'd0;
      shadow        <= 24'd0;
      width         <= 9'd0;
      byte_cnt      <= 9'd0;
      pix_cnt       <= 9'd0;
      rst_cnt       <= 3'd0;
      drain_cnt     <= '0;
    end else begin
      state     <= state_nx;
      dec_reset <= (state_nx == RST);
      if (start_yuv_we) shadow <= start_yuv;
      if (accept_line) begin
        dec_st        <= st;
        dec_start_yuv <= start_yuv_we ? start_yuv : shadow;
        width         <= st ? 9'd360 : 9'd384;
        byte_cnt      <= 9'd0;
        pix_cnt       <= 9'd0;
        rst_cnt       <= 3'd0;
        drain_cnt     <= '0;
      end else begin
        rst_cnt   <= (state == RST) ? rst_cnt + 3'd1 : 3'd0;
        drain_cnt <= (state == DRAIN) ? drain_cnt + DW'(1) : '0;
        if (byte_acc && byte_cnt != CNT_MAX) byte_cnt <= byte_cnt + 9'd1;
        if (pix_acc && pix_cnt != CNT_MAX) pix_cnt <= pix_cnt + 9'd1;
      end
    end
  end

`ifdef DYUV_LINE_STATS_EN
  // Underrun counter: RUN cycles where the decoder still wants bytes but the FIFO is empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= 16'd0;
    end else if (accept_line) begin
      stall_cnt <= 16'd0;
    end else if ((state == RUN) && !fifo_write && (byte_cnt < width) && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dyuv_line_sequencer.sv
// tb/tb_dyuv_line_sequencer.sv - randomized self-checking bench for dyuv_line_sequencer
// Stall statistics are checked when DYUV_LINE_STATS_EN is defined.
module tb_dyuv_line_sequencer;
  localparam int PIPE = 2;
  localparam int TMO  = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        line_start, dyuv_en, st, start_yuv_we, fifo_write;
  logic [23:0] start_yuv;
  logic [7:0]  fifo_pixel;
  logic        fifo_strobe, dec_reset, dec_st, dec_src_write, busy, line_done, line_abort, timeout;
  logic [23:0] dec_start_yuv;
  logic [7:0]  dec_src_pixel;
  logic        dec_src_strobe, dec_write, dec_strobe;
`ifdef DYUV_LINE_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [23:0] shadow_model = 24'd0;

  always #5 clk = ~clk;

  dyuv_line_sequencer dut (
    .clk(clk), .reset(reset), .line_start(line_start), .dyuv_en(dyuv_en), .st(st),
    .start_yuv(start_yuv), .start_yuv_we(start_yuv_we), .fifo_write(fifo_write),
    .fifo_pixel(fifo_pixel), .fifo_strobe(fifo_strobe), .dec_reset(dec_reset),
    .dec_st(dec_st), .dec_start_yuv(dec_start_yuv), .dec_src_write(dec_src_write),
    .dec_src_pixel(dec_src_pixel), .dec_src_strobe(dec_src_strobe), .dec_write(dec_write),
    .dec_strobe(dec_strobe), .busy(busy), .line_done(line_done), .line_abort(line_abort),
`ifdef DYUV_LINE_STATS_EN
    .stall_cnt(stall_cnt),
`endif
    .timeout(timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    line_start = 0; dyuv_en = 0; st = 0; start_yuv_we = 0; start_yuv = 24'd0;
    fifo_write = 0; fifo_pixel = 8'd0; dec_src_strobe = 0; dec_write = 0; dec_strobe = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic write_shadow(input logic [23:0] v);
    start_yuv = v; start_yuv_we = 1; step(); start_yuv_we = 0;
    shadow_model = v;
  endtask

  // Runs one line; the reference is the rule set: W bytes, W-PIPE pixels, RESET 2 cycles, timeout TMO after DRAIN entry.
  task automatic run_line(input bit st_i, input int pct, input int stop_pix, input int abort_at,
                          input bit do_mid, input logic [23:0] mid_yuv);
    int w, strobes, pix, pend, rst_cycles, stall, aborts, cyc, last_strobe, gap, bad_pix, after_strobe;
    bit done, tmo, aborted, we_done;
    logic [23:0] exp_yuv;
    w = st_i ? 360 : 384;
    exp_yuv = shadow_model;
    strobes = 0; pix = 0; pend = 0; rst_cycles = 0; stall = 0; aborts = 0;
    last_strobe = 0; gap = 0; bad_pix = 0; done = 0; tmo = 0; aborted = 0; we_done = 0;
    line_start = 1; dyuv_en = 1; st = st_i;
    @(negedge clk);
    chk("abort_on_idle_start", line_abort, 0);
    step();
    line_start = 0;
    for (cyc = 0; cyc < 4000 && !done; cyc++) begin
      fifo_write     = ($urandom_range(99) < pct);
      fifo_pixel     = 8'($urandom);
      dec_src_strobe = ($urandom_range(99) < pct);
      dec_write      = (pend > 0) && (pix < stop_pix);
      dec_strobe     = ($urandom_range(99) < pct);
      line_start     = (abort_at > 0) && !aborted && (strobes == abort_at);
      start_yuv_we   = do_mid && !we_done && (strobes == 50);
      start_yuv      = mid_yuv;
      @(negedge clk);
`ifdef DYUV_LINE_STATS_EN
      if (cyc == 0) chk("stall_clear", stall_cnt, 0);
`endif
      if (dec_src_write && dec_src_pixel !== fifo_pixel) bad_pix++;
      if (dec_reset) rst_cycles++;
      if (busy && !dec_reset && strobes < w && !fifo_write) stall++;
      if (dec_write && dec_strobe && busy && !dec_reset) begin pix++; pend--; end
      if (fifo_strobe) begin
        strobes++; last_strobe = cyc;
        if (strobes > PIPE) pend++;
      end
      if (line_abort) aborts++;
      if (start_yuv_we) begin we_done = 1; shadow_model = mid_yuv; end
      if (line_start) begin
        aborted = 1; strobes = 0; pix = 0; pend = 0; rst_cycles = 0; stall = 0;
        exp_yuv = shadow_model;
      end else if (line_done) begin
        done = 1; tmo = timeout; gap = cyc - last_strobe;
`ifdef DYUV_LINE_STATS_EN
        chk("stall_cnt", stall_cnt, stall);
`endif
      end
      step();
      line_start = 0; start_yuv_we = 0;
    end
    chk("line_done_seen", done, 1);
    chk("bytes_forwarded", strobes, w);
    chk("pixels_counted", pix, (stop_pix < w - PIPE) ? stop_pix : w - PIPE);
    chk("timeout_flag", tmo, stop_pix < w - PIPE);
    if (stop_pix < w - PIPE) chk("timeout_latency", gap, TMO + 1);
    chk("reset_cycles", rst_cycles, 2);
    chk("dec_st", dec_st, st_i);
    chk("dec_start_yuv", dec_start_yuv, exp_yuv);
    chk("abort_pulses", aborts, (abort_at > 0) ? 1 : 0);
    chk("src_pixel_pass", bad_pix, 0);
    // Extra FIFO bytes offered after the line must never be consumed.
    fifo_write = 1; dec_src_strobe = 1; dec_write = 0;
    after_strobe = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) chk("busy_after_done", busy, 0);
      if (fifo_strobe || line_done) after_strobe++;
      step();
    end
    chk("no_strobe_after_line", after_strobe, 0);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    step();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_dec_reset", dec_reset, 0);
    chk("rst_start_yuv", dec_start_yuv, 0);
    chk("rst_strobe", fifo_strobe, 0);
    chk("rst_done", {line_done, timeout, line_abort}, 0);
`ifdef DYUV_LINE_STATS_EN
    chk("rst_stall", stall_cnt, 0);
`endif
    step();
    reset = 0;
    step();

    write_shadow(24'h108080);
    line_start = 1; dyuv_en = 0;
    step();
    idle_inputs();
    @(negedge clk);
    chk("non_dyuv_ignored", {busy, dec_reset}, 0);
    step();

    run_line(0, 100, 1000, 0, 0, 24'h0);
    run_line(1, 100, 1000, 0, 0, 24'h0);
    run_line(0, 80, 1000, 0, 1, 24'h80FF00);
    chk("shadow_applied_next_line", shadow_model, 24'h80FF00);
    run_line(1, 85, 1000, 100, 0, 24'h0);
    run_line(0, 90, 300, 0, 0, 24'h0);
    for (int k = 0; k < 2; k++) begin
      write_shadow(24'($urandom));
      run_line(1'($urandom), 60 + $urandom_range(40), 1000, 0, 0, 24'h0);
    end

    line_start = 1; dyuv_en = 1; st = 0;
    step();
    idle_inputs();
    fifo_write = 1; dec_src_strobe = 1;
    repeat (10) step();
    #2 reset = 1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_dec_reset", dec_reset, 0);
    chk("async_rst_yuv", dec_start_yuv, 0);
    chk("async_rst_strobe", fifo_strobe, 0);
    step();
    reset = 0;
    step();
    @(negedge clk);
    chk("post_rst_dec_reset", dec_reset, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
